// File: rtl/lcm_seg_pkg.sv
// lcm_seg_pkg: shared state encoding and frame-size derived widths for the LCM threshold segmenter
package lcm_seg_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} seg_state_e;
  function automatic int pix_log2(input int w, input int h);
    return $clog2(w * h);
  endfunction
  function automatic int sum_width(input int dw, input int w, input int h);
    return dw + pix_log2(w, h);
  endfunction
  function automatic int cnt_width(input int w, input int h);
    return pix_log2(w, h) + 1;
  endfunction
endpackage

// File: rtl/lcm_thresh_seg_frame_stats_accum.sv
// frame_stats_accum: per-frame pixel sum, max and saturating count
module frame_stats_accum import lcm_seg_pkg::*; #(
  parameter int DW = 8,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  localparam int SUM_W = sum_width(DW, IMG_W, IMG_H),
  localparam int CW = cnt_width(IMG_W, IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             acc,
  input  logic [DW-1:0]    pix,
  output logic [SUM_W-1:0] sum,
  output logic [DW-1:0]    px_max,
  output logic [CW-1:0]    cnt
);
  localparam logic [CW-1:0] NPIX = CW'(IMG_W * IMG_H);
  logic [SUM_W-1:0] sum_q, sum_d, base_sum;
  logic [DW-1:0] max_q, max_d, base_max;
  logic [CW-1:0] cnt_q, cnt_d, base_cnt;
  logic room;
  always_comb begin
    base_sum = clr ? '0 : sum_q;
    base_max = clr ? '0 : max_q;
    base_cnt = clr ? '0 : cnt_q;
    room = base_cnt < NPIX;
    sum_d = (acc && room) ? base_sum + SUM_W'(pix) : base_sum;
    max_d = (acc && room && pix > base_max) ? pix : base_max;
    cnt_d = acc ? (room ? base_cnt + 1'b1 : NPIX + 1'b1) : base_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      max_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      max_q <= max_d;
      cnt_q <= cnt_d;
    end
  end
  assign sum = sum_q;
  assign px_max = max_q;
  assign cnt = cnt_q;
endmodule

// File: rtl/lcm_thresh_seg.sv
// lcm_thresh_seg: binary mask from previous valid frame's mean/max threshold; LCM_SEG_THRESH_IIR_EN enables IIR threshold smoothing
module lcm_thresh_seg import lcm_seg_pkg::*; #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_IMAGE_WIDTH = 256,
  parameter int P_IMAGE_HEIGHT = 256,
  parameter int P_K_NUM = 12,
  parameter int P_INIT_THRESH = 128,
  localparam int PIX_LOG2 = pix_log2(P_IMAGE_WIDTH, P_IMAGE_HEIGHT),
  localparam int SUM_W = sum_width(P_DATA_WIDTH, P_IMAGE_WIDTH, P_IMAGE_HEIGHT),
  localparam int CW = cnt_width(P_IMAGE_WIDTH, P_IMAGE_HEIGHT)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_v_sync,
  input  logic                    i_h_sync,
  input  logic [P_DATA_WIDTH-1:0] i_img_data,
  output logic                    o_v_sync,
  output logic                    o_h_sync,
  output logic [P_DATA_WIDTH-1:0] o_img_data,
  output logic                    o_frame_err
);
  localparam int DW = P_DATA_WIDTH;
  localparam logic [CW-1:0] NPIX = CW'(P_IMAGE_WIDTH * P_IMAGE_HEIGHT);
  seg_state_e state_q, state_d;
  logic v_prev_q, v1_q, h1_q, ov_q, oh_q, err_q, err_d, mask_d;
  logic rise, clr, acc, upd_ok;
  logic [DW-1:0] d1_q, od_q, thr_q, thr_d, mean, t, t_load, px_max;
  logic [DW+4:0] prod;
  logic [SUM_W-1:0] sum;
  logic [CW-1:0] cnt;
  frame_stats_accum #(
    .DW(DW),
    .IMG_W(P_IMAGE_WIDTH),
    .IMG_H(P_IMAGE_HEIGHT)
  ) u_stats (
    .clk(i_clk),
    .rst(i_rst),
    .clr(clr),
    .acc(acc),
    .pix(i_img_data),
    .sum(sum),
    .px_max(px_max),
    .cnt(cnt)
  );
  always_comb begin
    rise = i_v_sync & ~v_prev_q;
    clr = rise & (state_q != ACCUM);
    acc = i_v_sync & i_h_sync & (clr | (state_q == ACCUM));
    state_d = clr ? ACCUM : (state_q == ACCUM) ? (i_v_sync ? ACCUM : UPDATE) : IDLE;
    mean = DW'(sum >> PIX_LOG2);
    prod = (DW + 5)'(px_max - mean) * (DW + 5)'(P_K_NUM);
    t = mean + DW'(prod >> 4);
`ifdef LCM_SEG_THRESH_IIR_EN
    t_load = DW'(({1'b0, thr_q} + {1'b0, t}) >> 1);
`else
    t_load = t;
`endif
    upd_ok = cnt == NPIX;
    thr_d = (state_q == UPDATE && upd_ok) ? t_load : thr_q;
    err_d = (state_q == UPDATE) && !upd_ok;
    mask_d = h1_q & v1_q & (d1_q > thr_q);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      v_prev_q <= i_v_sync;
      v1_q <= 1'b0;
      h1_q <= 1'b0;
      d1_q <= '0;
      ov_q <= 1'b0;
      oh_q <= 1'b0;
      od_q <= '0;
      err_q <= 1'b0;
      thr_q <= DW'(P_INIT_THRESH);
    end else begin
      state_q <= state_d;
      v_prev_q <= i_v_sync;
      v1_q <= i_v_sync;
      h1_q <= i_h_sync;
      d1_q <= i_img_data;
      ov_q <= v1_q;
      oh_q <= h1_q;
      od_q <= {DW{mask_d}};
      err_q <= err_d;
      thr_q <= thr_d;
    end
  end
  assign o_v_sync = ov_q;
  assign o_h_sync = oh_q;
  assign o_img_data = od_q;
  assign o_frame_err = err_q;
endmodule

// File: tb/tb_lcm_thresh_seg.sv
// tb_lcm_thresh_seg: scoreboard bench for lcm_thresh_seg on 4x4 frames
module tb_lcm_thresh_seg;
`ifdef LCM_SEG_THRESH_IIR_EN
  localparam int T1 = 128, T2 = 140, T4 = 75;
`else
  localparam int T1 = 129, T2 = 153, T4 = 10;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v = 1'b0;
  logic h = 1'b0;
  logic [7:0] d = 8'd0;
  logic ov, oh, ferr;
  logic [7:0] od;
  logic [7:0] exp_q[$];
  logic [7:0] fr[$];
  int n_chk = 0;
  int n_pass = 0;
  int n_err = 0;
  int exp_thr = 128;
  int e0;
  always #5 clk = ~clk;
  lcm_thresh_seg #(
    .P_DATA_WIDTH(8),
    .P_IMAGE_WIDTH(4),
    .P_IMAGE_HEIGHT(4),
    .P_K_NUM(12),
    .P_INIT_THRESH(128)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_v_sync(v),
    .i_h_sync(h),
    .i_img_data(d),
    .o_v_sync(ov),
    .o_h_sync(oh),
    .o_img_data(od),
    .o_frame_err(ferr)
  );
  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask
  always @(negedge clk) begin
    if (ferr) n_err++;
    if (ov && oh) begin
      if (exp_q.size() == 0) check("unexpected_pixel", 1, 0);
      else check("mask", int'(od), int'(exp_q.pop_front()));
    end
  end
  task automatic drive(input logic vv, input logic hh, input logic [7:0] dd);
    @(posedge clk);
    #1;
    v = vv;
    h = hh;
    d = dd;
    if (vv && hh) exp_q.push_back(int'(dd) > exp_thr ? 8'hFF : 8'h00);
  endtask
  task automatic fill(input int n, input logic [7:0] val);
    fr.delete();
    for (int i = 0; i < n; i++) fr.push_back(val);
  endtask
  task automatic probe();
    fr.delete();
    for (int i = 0; i < 16; i++) fr.push_back(8'(exp_thr + (i % 2)));
  endtask
  task automatic send_frame(input int gap);
    foreach (fr[i]) drive(1'b1, 1'b1, fr[i]);
    for (int i = 0; i < gap; i++) drive(1'b0, 1'b0, 8'd0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_o_v_sync", int'(ov), 0);
    check("rst_o_h_sync", int'(oh), 0);
    check("rst_o_img_data", int'(od), 0);
    check("rst_o_frame_err", int'(ferr), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    e0 = n_err;
    fill(16, 8'd129);
    send_frame(2);
    drive(1'b0, 1'b1, 8'd255);
    drive(1'b0, 1'b0, 8'd0);
    check("f1_no_err", n_err - e0, 0);
    exp_thr = T1;
    fill(16, 8'd0);
    fr[0] = 8'd200;
    send_frame(4);
    exp_thr = T2;
    probe();
    send_frame(4);
    fill(16, 8'd10);
    send_frame(1);
    exp_thr = T4;
    probe();
    send_frame(4);
    check("valid_frames_no_err", n_err - e0, 0);
    e0 = n_err;
    fill(15, 8'd255);
    send_frame(4);
    check("short_frame_err_pulses", n_err - e0, 1);
    e0 = n_err;
    probe();
    send_frame(4);
    check("probe_after_short_no_err", n_err - e0, 0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 8'd255);
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b1, 1'b0, 8'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_o_v_sync", int'(ov), 0);
    check("midrst_o_h_sync", int'(oh), 0);
    check("midrst_o_img_data", int'(od), 0);
    check("midrst_o_frame_err", int'(ferr), 0);
    exp_thr = 128;
    e0 = n_err;
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 8'd255);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'd0);
    check("midrst_rest_no_err", n_err - e0, 0);
    probe();
    send_frame(4);
    repeat (5) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
